otbn_pc_sequencer: RTL and testbench
====================================

Name: otbn_pc_sequencer

Overview:
Upstream neighbour of the instruction fetch stage. It owns the program counter and a hardware loop stack, and each cycle produces the next fetch request address and valid. It also drives the prefetch loop hints: active, iterations, end address and jump address. Sequential execution, taken branches/jumps, LOOP/LOOPI entry and loop-end wrap-around are all resolved here.

Parameters:
ImemSizeByte, 4096, IMEM size in bytes; ImemAddrWidth = prim_util_pkg::vbits(ImemSizeByte) (localparam)
LoopStackDepth, 8, maximum number of nested active loops

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
start_i  in  1  one-cycle pulse; begin execution at start_addr_i
start_addr_i  in  ImemAddrWidth  first instruction address
halt_i  in  1  stop execution (ECALL/end); return to IDLE
err_i  in  1  fatal error from elsewhere; enter ERROR
insn_done_i  in  1  current instruction retires this cycle (stall already excluded)
branch_taken_i  in  1  retiring instruction redirects control flow
branch_target_i  in  ImemAddrWidth  redirect target
loop_start_i  in  1  retiring instruction is LOOP/LOOPI
loop_iterations_i  in  32  iteration count of the new loop
loop_bodysize_i  in  12  body length in instructions
insn_fetch_req_valid_o  out  1  fetch request valid
insn_fetch_req_addr_o  out  ImemAddrWidth  fetch request address
prefetch_en_o  out  1  prefetch enable
prefetch_loop_active_o  out  1  loop stack non-empty
prefetch_loop_iterations_o  out  32  remaining iterations of top loop
prefetch_loop_end_addr_o  out  ImemAddrWidth+1  address of last body instruction of top loop
prefetch_loop_jump_addr_o  out  ImemAddrWidth  start address of top loop body
busy_o  out  1  state is RUN
loop_err_o  out  1  sticky: stack overflow, zero iterations, bodysize 0, or end beyond IMEM

Behaviour:
- Reset: state IDLE, PC 0, stack empty, every output 0.
- FSM IDLE -> RUN on start_i: PC <= start_addr_i; req_valid_o=1 from the next cycle. In IDLE, prefetch_en_o follows start_i so the first address is prefetched.
- RUN -> IDLE on halt_i. RUN/IDLE -> ERROR on err_i or a new loop_err_o. ERROR is left only by reset. halt_i and err_i together: ERROR wins.
- In RUN: insn_fetch_req_valid_o=1, insn_fetch_req_addr_o=PC, prefetch_en_o=1. In IDLE/ERROR: all three are 0. The stack is cleared on entering IDLE.
- PC update applies only when insn_done_i; otherwise PC holds (stall). Priority:
  1. branch_taken_i: PC <= target.
  2. PC == top.end: if top.iter > 1 then top.iter--, PC <= top.start; else pop, PC <= PC+4.
  3. Otherwise PC <= PC+4.
- loop_start_i (with insn_done_i): push {start=PC+4, end=PC+4*bodysize (ImemAddrWidth+1 bits, no truncation), iter=loop_iterations_i}. PC <= PC+4.
- Push faults, each setting loop_err_o with no push:
  - stack already holds LoopStackDepth entries (overflow);
  - iterations == 0;
  - bodysize == 0;
  - end bit ImemAddrWidth set.
- PC+4 wraps modulo 2^ImemAddrWidth; no error is raised for the wrap.
- Single-instruction loop: start == end, handled by rule 2 every retire.
- Prefetch hint outputs reflect the top entry combinationally from registered state; all are 0 when the stack is empty.
- Stack entries are not cleared on pop (no-wipe); only the pointer moves. Reset clears both.

Optional Feature:
OTBN_PC_SEQ_LOOP_END_BRANCH_CHECK_EN
- Defined: branch_taken_i at PC == top.end sets loop_err_o and enters ERROR.
- Undefined: the branch wins silently per priority 1 and the loop entry is left on the stack.

Decomposition:
- otbn_pkg additions:
  - pc_seq_state_e {PcSeqIdle, PcSeqRun, PcSeqError};
  - loop_stack_entry_t {start, end, iterations};
  - LoopStackDepth default constant.
- Sub-module otbn_pc_seq_loop_stack:
  - push/pop/dec_iter/clear inputs;
  - top entry, empty and full outputs;
  - pointer of width $clog2(LoopStackDepth+1).

Test Plan:
- Start at 0x100, 3 retires with no stall -> req_addr 0x100, 0x104, 0x108, 0x10C. Stall (insn_done_i=0) for 2 cycles holds 0x10C.
- LOOPI at 0x200, iter 3, bodysize 2 -> addrs 0x204, 0x208, then 0x204, 0x208 twice more, then 0x20C. prefetch_loop_end_addr_o=0x208 and iterations 3/2/1 during the loop; active_o drops after the pop.
- Nested loops (outer iter 2 body 4, inner iter 2 body 1) -> inner instruction repeats twice per outer iteration; total 10 retires before exit.
- Push 9 loops with LoopStackDepth=8 -> ninth sets loop_err_o, state ERROR, req_valid_o=0 next cycle.
- Branch taken to 0x040 while a loop is active; halt_i then start_i -> stack empty, active_o=0 after the restart.
- Loop with end address ≥ 4096 or iter=0 -> loop_err_o=1, no PC advance beyond the error cycle.

Source files
------------

// File: rtl/otbn_pc_sequencer_pkg.sv
// rtl/otbn_pc_sequencer_pkg.sv - shared types and constants for the PC sequencer
package otbn_pc_sequencer_pkg;

  // Address width for a memory of the given byte size (at least 1 bit)
  function automatic int vbits(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  localparam int PcSeqImemSizeByte     = 4096;
  localparam int PcSeqImemAddrWidth    = vbits(PcSeqImemSizeByte);
  localparam int LoopStackDepthDefault = 8;

  typedef enum logic [1:0] {
    PcSeqIdle,
    PcSeqRun,
    PcSeqError
  } pc_seq_state_e;

  // end_addr carries one extra bit so an out-of-range loop end is visible
  typedef struct packed {
    logic [PcSeqImemAddrWidth-1:0] start_addr;
    logic [PcSeqImemAddrWidth:0]   end_addr;
    logic [31:0]                   iterations;
  } loop_stack_entry_t;

endpackage

// File: rtl/otbn_pc_seq_loop_stack.sv
// rtl/otbn_pc_seq_loop_stack.sv - hardware loop stack with top-of-stack view
module otbn_pc_seq_loop_stack
  import otbn_pc_sequencer_pkg::*;
#(
  parameter int Depth = LoopStackDepthDefault
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              push_i,
  input  loop_stack_entry_t push_entry_i,
  input  logic              pop_i,
  input  logic              dec_iter_i,
  output loop_stack_entry_t top_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int PtrW = $clog2(Depth + 1);

  loop_stack_entry_t entries_q [Depth];
  logic [PtrW-1:0]   ptr_q;

  assign empty_o = (ptr_q == '0);
  assign full_o  = (ptr_q == PtrW'(Depth));

  // Top entry is the one just below the pointer; zero when empty
  always_comb begin
    top_o = '0;
    for (int i = 0; i < Depth; i++) begin
      if (ptr_q == PtrW'(i + 1)) top_o = entries_q[i];
    end
  end

  // Pointer and entry storage; popped entries keep their contents
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      for (int i = 0; i < Depth; i++) entries_q[i] <= '0;
    end else begin
      if (clear_i) begin
        ptr_q <= '0;
      end else if (push_i && !full_o) begin
        ptr_q <= ptr_q + 1'b1;
      end else if (pop_i && !empty_o) begin
        ptr_q <= ptr_q - 1'b1;
      end
      for (int i = 0; i < Depth; i++) begin
        if (!clear_i && push_i && !full_o && ptr_q == PtrW'(i)) begin
          entries_q[i] <= push_entry_i;
        end else if (!clear_i && dec_iter_i && ptr_q == PtrW'(i + 1)) begin
          entries_q[i].iterations <= entries_q[i].iterations - 32'd1;
        end
      end
    end
  end

endmodule

// File: rtl/otbn_pc_sequencer.sv
// rtl/otbn_pc_sequencer.sv - PC, loop stack and fetch request generation (option: OTBN_PC_SEQ_LOOP_END_BRANCH_CHECK_EN)
module otbn_pc_sequencer
  import otbn_pc_sequencer_pkg::*;
#(
  parameter int  ImemSizeByte   = PcSeqImemSizeByte,
  parameter int  LoopStackDepth = LoopStackDepthDefault,
  localparam int ImemAddrWidth  = vbits(ImemSizeByte)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [ImemAddrWidth-1:0] start_addr_i,
  input  logic                     halt_i,
  input  logic                     err_i,
  input  logic                     insn_done_i,
  input  logic                     branch_taken_i,
  input  logic [ImemAddrWidth-1:0] branch_target_i,
  input  logic                     loop_start_i,
  input  logic [31:0]              loop_iterations_i,
  input  logic [11:0]              loop_bodysize_i,
  output logic                     insn_fetch_req_valid_o,
  output logic [ImemAddrWidth-1:0] insn_fetch_req_addr_o,
  output logic                     prefetch_en_o,
  output logic                     prefetch_loop_active_o,
  output logic [31:0]              prefetch_loop_iterations_o,
  output logic [ImemAddrWidth:0]   prefetch_loop_end_addr_o,
  output logic [ImemAddrWidth-1:0] prefetch_loop_jump_addr_o,
  output logic                     busy_o,
  output logic                     loop_err_o
);

  pc_seq_state_e            state_q, state_d;
  logic [ImemAddrWidth-1:0] pc_q, pc_d;
  logic                     loop_err_q, loop_err_d;

  logic              stack_push, stack_pop, stack_dec, stack_clear;
  logic              stack_empty, stack_full;
  loop_stack_entry_t stack_top, push_entry;

  logic [ImemAddrWidth-1:0] pc_plus4;
  logic [31:0]              new_end_full;
  logic                     end_overflow, loop_req, loop_fault, branch_end_fault;
  logic                     at_loop_end, new_err;

  assign pc_plus4     = pc_q + ImemAddrWidth'(4);
  assign new_end_full = 32'(pc_q) + {18'b0, loop_bodysize_i, 2'b00};
  assign end_overflow = |new_end_full[31:ImemAddrWidth];
  assign at_loop_end  = !stack_empty && ({1'b0, pc_q} == stack_top.end_addr);

  assign loop_req   = insn_done_i && loop_start_i && !branch_taken_i;
  assign loop_fault = loop_req && (stack_full || (loop_iterations_i == 32'd0) ||
                                   (loop_bodysize_i == 12'd0) || end_overflow);
`ifdef OTBN_PC_SEQ_LOOP_END_BRANCH_CHECK_EN
  assign branch_end_fault = insn_done_i && branch_taken_i && at_loop_end;
`else
  assign branch_end_fault = 1'b0;
`endif
  assign new_err = loop_fault || branch_end_fault;

  assign push_entry.start_addr = pc_plus4;
  assign push_entry.end_addr   = new_end_full[ImemAddrWidth:0];
  assign push_entry.iterations = loop_iterations_i;

  otbn_pc_seq_loop_stack #(
    .Depth(LoopStackDepth)
  ) u_loop_stack (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (stack_clear),
    .push_i      (stack_push),
    .push_entry_i(push_entry),
    .pop_i       (stack_pop),
    .dec_iter_i  (stack_dec),
    .top_o       (stack_top),
    .empty_o     (stack_empty),
    .full_o      (stack_full)
  );

  // Next-state, next-PC, stack control and fetch outputs
  always_comb begin
    state_d                = state_q;
    pc_d                   = pc_q;
    loop_err_d             = loop_err_q;
    stack_push             = 1'b0;
    stack_pop              = 1'b0;
    stack_dec              = 1'b0;
    stack_clear            = 1'b0;
    insn_fetch_req_valid_o = 1'b0;
    insn_fetch_req_addr_o  = '0;
    prefetch_en_o          = 1'b0;
    unique case (state_q)
      PcSeqIdle: begin
        prefetch_en_o = start_i;
        if (err_i) begin
          state_d = PcSeqError;
        end else if (start_i) begin
          state_d = PcSeqRun;
          pc_d    = start_addr_i;
        end
      end
      PcSeqRun: begin
        insn_fetch_req_valid_o = 1'b1;
        insn_fetch_req_addr_o  = pc_q;
        prefetch_en_o          = 1'b1;
        if (err_i || new_err) begin
          state_d    = PcSeqError;
          loop_err_d = loop_err_q | new_err;
        end else if (halt_i) begin
          state_d     = PcSeqIdle;
          stack_clear = 1'b1;
        end else if (insn_done_i) begin
          if (branch_taken_i) begin
            pc_d = branch_target_i;
          end else if (loop_start_i) begin
            stack_push = 1'b1;
            pc_d       = pc_plus4;
          end else if (at_loop_end) begin
            if (stack_top.iterations > 32'd1) begin
              stack_dec = 1'b1;
              pc_d      = stack_top.start_addr;
            end else begin
              stack_pop = 1'b1;
              pc_d      = pc_plus4;
            end
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      PcSeqError: ;
      default: state_d = PcSeqIdle;
    endcase
  end

  // State, PC and sticky loop error registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= PcSeqIdle;
      pc_q       <= '0;
      loop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      loop_err_q <= loop_err_d;
    end
  end

  assign busy_o                     = (state_q == PcSeqRun);
  assign loop_err_o                 = loop_err_q;
  assign prefetch_loop_active_o     = !stack_empty;
  assign prefetch_loop_iterations_o = stack_top.iterations;
  assign prefetch_loop_end_addr_o   = stack_top.end_addr;
  assign prefetch_loop_jump_addr_o  = stack_top.start_addr;

endmodule

// File: tb/tb_otbn_pc_sequencer.sv
// tb/tb_otbn_pc_sequencer.sv - self-checking bench for otbn_pc_sequencer
module tb_otbn_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [11:0] start_addr_i;
  logic        halt_i;
  logic        err_i;
  logic        insn_done_i;
  logic        branch_taken_i;
  logic [11:0] branch_target_i;
  logic        loop_start_i;
  logic [31:0] loop_iterations_i;
  logic [11:0] loop_bodysize_i;
  logic        insn_fetch_req_valid_o;
  logic [11:0] insn_fetch_req_addr_o;
  logic        prefetch_en_o;
  logic        prefetch_loop_active_o;
  logic [31:0] prefetch_loop_iterations_o;
  logic [12:0] prefetch_loop_end_addr_o;
  logic [11:0] prefetch_loop_jump_addr_o;
  logic        busy_o;
  logic        loop_err_o;

  otbn_pc_sequencer dut (
    .clk_i                     (clk),
    .rst_ni                    (rst_ni),
    .start_i                   (start_i),
    .start_addr_i              (start_addr_i),
    .halt_i                    (halt_i),
    .err_i                     (err_i),
    .insn_done_i               (insn_done_i),
    .branch_taken_i            (branch_taken_i),
    .branch_target_i           (branch_target_i),
    .loop_start_i              (loop_start_i),
    .loop_iterations_i         (loop_iterations_i),
    .loop_bodysize_i           (loop_bodysize_i),
    .insn_fetch_req_valid_o    (insn_fetch_req_valid_o),
    .insn_fetch_req_addr_o     (insn_fetch_req_addr_o),
    .prefetch_en_o             (prefetch_en_o),
    .prefetch_loop_active_o    (prefetch_loop_active_o),
    .prefetch_loop_iterations_o(prefetch_loop_iterations_o),
    .prefetch_loop_end_addr_o  (prefetch_loop_end_addr_o),
    .prefetch_loop_jump_addr_o (prefetch_loop_jump_addr_o),
    .busy_o                    (busy_o),
    .loop_err_o                (loop_err_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: program counter plus a queue of active loops
  typedef struct {
    int          start;
    int          last;
    logic [31:0] iters;
  } mloop_t;

  localparam int MIdle = 0, MRun = 1, MErr = 2;
  localparam int ImemBytes = 4096;
  localparam int Depth = 8;

  mloop_t mstack[$];
  int     mmode = MIdle;
  int     mpc = 0;
  bit     mlerr = 1'b0;
  bit     armed = 1'b0;

  task automatic model_step();
    int     ends;
    bit     fault;
    mloop_t t;
    armed = 1'b1;
    if (!rst_ni) begin
      mmode = MIdle; mpc = 0; mlerr = 1'b0; mstack.delete();
    end else if (mmode == MIdle) begin
      if (err_i) mmode = MErr;
      else if (start_i) begin mmode = MRun; mpc = int'(start_addr_i); end
    end else if (mmode == MRun) begin
      fault = 1'b0;
      ends  = mpc + 4 * int'(loop_bodysize_i);
      if (insn_done_i && loop_start_i && !branch_taken_i)
        fault = (mstack.size() >= Depth) || (loop_iterations_i == 0) ||
                (loop_bodysize_i == 0) || (ends >= ImemBytes);
`ifdef OTBN_PC_SEQ_LOOP_END_BRANCH_CHECK_EN
      if (insn_done_i && branch_taken_i && mstack.size() > 0 && mpc == mstack[mstack.size()-1].last)
        fault = 1'b1;
`endif
      if (err_i || fault) begin
        mmode = MErr;
        if (fault) mlerr = 1'b1;
      end else if (halt_i) begin
        mmode = MIdle;
        mstack.delete();
      end else if (insn_done_i) begin
        if (branch_taken_i) begin
          mpc = int'(branch_target_i);
        end else if (loop_start_i) begin
          t.start = (mpc + 4) % ImemBytes; t.last = ends; t.iters = loop_iterations_i;
          mstack.push_back(t);
          mpc = (mpc + 4) % ImemBytes;
        end else if (mstack.size() > 0 && mpc == mstack[mstack.size()-1].last) begin
          t = mstack[mstack.size()-1];
          if (t.iters > 1) begin
            t.iters = t.iters - 1;
            mstack[mstack.size()-1] = t;
            mpc = t.start;
          end else begin
            void'(mstack.pop_back());
            mpc = (mpc + 4) % ImemBytes;
          end
        end else begin
          mpc = (mpc + 4) % ImemBytes;
        end
      end
    end
  endtask

  task automatic compare();
    bit     run;
    bit     act;
    mloop_t t;
    run = (mmode == MRun);
    act = (mstack.size() > 0);
    t.start = 0; t.last = 0; t.iters = 0;
    if (act) t = mstack[mstack.size()-1];
    check("cmp_valid",  32'(insn_fetch_req_valid_o), 32'(run));
    check("cmp_addr",   32'(insn_fetch_req_addr_o), run ? 32'(mpc) : 32'd0);
    check("cmp_pf_en",  32'(prefetch_en_o), 32'(run || (mmode == MIdle && start_i)));
    check("cmp_busy",   32'(busy_o), 32'(run));
    check("cmp_active", 32'(prefetch_loop_active_o), 32'(act));
    check("cmp_iters",  prefetch_loop_iterations_o, t.iters);
    check("cmp_end",    32'(prefetch_loop_end_addr_o), 32'(t.last));
    check("cmp_jump",   32'(prefetch_loop_jump_addr_o), 32'(t.start));
    check("cmp_lerr",   32'(loop_err_o), 32'(mlerr));
  endtask

  // Model advances on every active edge, compare on the opposite edge
  always @(posedge clk) model_step();
  always @(negedge clk) if (armed) compare();

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic peek();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_in();
    start_i = 0; halt_i = 0; err_i = 0; insn_done_i = 0; branch_taken_i = 0;
    loop_start_i = 0;
  endtask

  task automatic do_reset();
    clear_in();
    rst_ni = 0;
    tick();
    rst_ni = 1;
  endtask

  task automatic do_start(input logic [11:0] a);
    start_i = 1; start_addr_i = a;
    tick();
    start_i = 0;
  endtask

  task automatic do_halt();
    halt_i = 1;
    tick();
    halt_i = 0;
  endtask

  int t2_addr[7] = '{'h204, 'h208, 'h204, 'h208, 'h204, 'h208, 'h20C};
  int t2_it[7]   = '{3, 3, 2, 2, 1, 1, 0};
  int t3_addr[11] = '{'h304, 'h308, 'h308, 'h30C, 'h310, 'h304, 'h308, 'h308, 'h30C, 'h310, 'h314};

  initial begin
    clear_in();
    start_addr_i = 0; branch_target_i = 0; loop_iterations_i = 0; loop_bodysize_i = 0;
    rst_ni = 0;
    tick(); tick();
    rst_ni = 1;
    peek();
    check("rst_valid",  32'(insn_fetch_req_valid_o), 0);
    check("rst_addr",   32'(insn_fetch_req_addr_o), 0);
    check("rst_pf_en",  32'(prefetch_en_o), 0);
    check("rst_busy",   32'(busy_o), 0);
    check("rst_active", 32'(prefetch_loop_active_o), 0);
    check("rst_lerr",   32'(loop_err_o), 0);
    tick();

    // Sequential fetch and stall
    start_i = 1; start_addr_i = 12'h100;
    peek();
    check("t1_pf_follows_start", 32'(prefetch_en_o), 1);
    tick();
    start_i = 0; insn_done_i = 1;
    for (int i = 0; i < 3; i++) begin
      peek(); check("t1_seq_addr", 32'(insn_fetch_req_addr_o), 32'h100 + 32'(4 * i)); tick();
    end
    insn_done_i = 0;
    for (int i = 0; i < 3; i++) begin
      peek(); check("t1_stall_addr", 32'(insn_fetch_req_addr_o), 32'h10C); tick();
    end

    // LOOPI iter 3 body 2 at 0x200
    do_halt();
    do_start(12'h200);
    insn_done_i = 1; loop_start_i = 1; loop_iterations_i = 3; loop_bodysize_i = 2;
    peek(); check("t2_loop_addr", 32'(insn_fetch_req_addr_o), 32'h200); tick();
    loop_start_i = 0;
    for (int i = 0; i < 7; i++) begin
      peek();
      check("t2_addr", 32'(insn_fetch_req_addr_o), 32'(t2_addr[i]));
      check("t2_iters", prefetch_loop_iterations_o, 32'(t2_it[i]));
      check("t2_active", 32'(prefetch_loop_active_o), 32'(i < 6));
      if (i < 6) check("t2_end", 32'(prefetch_loop_end_addr_o), 32'h208);
      tick();
    end
    insn_done_i = 0;

    // Nested loops: outer iter 2 body 4, inner iter 2 body 1
    do_halt();
    do_start(12'h300);
    insn_done_i = 1; loop_start_i = 1; loop_iterations_i = 2; loop_bodysize_i = 4;
    tick();
    loop_start_i = 0;
    for (int i = 0; i < 11; i++) begin
      peek();
      check("t3_addr", 32'(insn_fetch_req_addr_o), 32'(t3_addr[i]));
      if (i < 10) begin
        loop_start_i = (t3_addr[i] == 'h304); loop_iterations_i = 2; loop_bodysize_i = 1;
        tick();
      end
    end
    insn_done_i = 0; loop_start_i = 0;
    tick();

    // Nine pushes overflow an eight-deep stack
    do_halt();
    do_start(12'h000);
    insn_done_i = 1; loop_start_i = 1; loop_iterations_i = 5; loop_bodysize_i = 200;
    for (int k = 0; k < 9; k++) begin
      peek();
      check("t4_push_addr", 32'(insn_fetch_req_addr_o), 32'(4 * k));
      if (k == 8) check("t4_lerr_before", 32'(loop_err_o), 0);
      tick();
    end
    clear_in();
    peek();
    check("t4_lerr", 32'(loop_err_o), 1);
    check("t4_valid", 32'(insn_fetch_req_valid_o), 0);
    check("t4_busy", 32'(busy_o), 0);
    tick();
    do_reset();
    peek();
    check("t4_rst_lerr", 32'(loop_err_o), 0);
    check("t4_rst_active", 32'(prefetch_loop_active_o), 0);
    tick();

    // Branch out of an active loop, then halt and restart
    do_start(12'h400);
    insn_done_i = 1; loop_start_i = 1; loop_iterations_i = 4; loop_bodysize_i = 3;
    tick();
    loop_start_i = 0; branch_taken_i = 1; branch_target_i = 12'h040;
    peek(); check("t5_pre_branch", 32'(insn_fetch_req_addr_o), 32'h404); tick();
    branch_taken_i = 0; insn_done_i = 0;
    peek();
    check("t5_branch_addr", 32'(insn_fetch_req_addr_o), 32'h040);
    check("t5_loop_kept", 32'(prefetch_loop_active_o), 1);
    check("t5_jump", 32'(prefetch_loop_jump_addr_o), 32'h404);
    check("t5_end", 32'(prefetch_loop_end_addr_o), 32'h40C);
    tick();
    do_halt();
    peek(); check("t5_idle_active", 32'(prefetch_loop_active_o), 0); tick();
    do_start(12'h080);
    peek();
    check("t5_restart_addr", 32'(insn_fetch_req_addr_o), 32'h080);
    check("t5_restart_active", 32'(prefetch_loop_active_o), 0);
    check("t5_restart_iters", prefetch_loop_iterations_o, 0);
    tick();

    // Loop end beyond IMEM, zero iterations, zero body size
    do_halt();
    do_start(12'hFF0);
    insn_done_i = 1; loop_start_i = 1; loop_iterations_i = 2; loop_bodysize_i = 8;
    tick();
    clear_in();
    peek();
    check("t6_end_lerr", 32'(loop_err_o), 1);
    check("t6_end_valid", 32'(insn_fetch_req_valid_o), 0);
    check("t6_end_addr", 32'(insn_fetch_req_addr_o), 0);
    tick();
    do_reset();
    do_start(12'h500);
    insn_done_i = 1; loop_start_i = 1; loop_iterations_i = 0; loop_bodysize_i = 2;
    tick();
    clear_in();
    peek(); check("t6_iter0_lerr", 32'(loop_err_o), 1); tick();
    do_reset();
    do_start(12'h600);
    insn_done_i = 1; loop_start_i = 1; loop_iterations_i = 1; loop_bodysize_i = 0;
    tick();
    clear_in();
    peek(); check("t6_body0_lerr", 32'(loop_err_o), 1); tick();
    do_reset();

    // PC wrap, then halt with err: error wins and is not a loop error
    do_start(12'hFFC);
    insn_done_i = 1;
    tick();
    insn_done_i = 0;
    peek(); check("t7_wrap_addr", 32'(insn_fetch_req_addr_o), 0); tick();
    halt_i = 1; err_i = 1;
    tick();
    clear_in();
    peek();
    check("t7_err_busy", 32'(busy_o), 0);
    check("t7_err_lerr", 32'(loop_err_o), 0);
    tick();
    do_start(12'h100);
    peek(); check("t7_err_sticky", 32'(insn_fetch_req_valid_o), 0); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
